// File: rtl/traffic_pkg.sv
// Shared definitions for the highway / country-road traffic controller.
// Holds the 2-bit lamp codes, the fixed 3-bit state encoding, the lamp
// pair struct and the state-to-lamp decode used by the controller.
package traffic_pkg;

  typedef logic [1:0] lamp_t;

  localparam lamp_t RED    = 2'd0;
  localparam lamp_t YELLOW = 2'd1;
  localparam lamp_t GREEN  = 2'd2;

  // Encoding is fixed: external checkers probe the state register directly.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // hwy GREEN,  cntry RED
    S1 = 3'd1,  // hwy YELLOW, cntry RED
    S2 = 3'd2,  // hwy RED,    cntry RED
    S3 = 3'd3,  // hwy RED,    cntry GREEN
    S4 = 3'd4   // hwy RED,    cntry YELLOW
  } state_e;

  typedef struct packed {
    lamp_t hwy;
    lamp_t cntry;
  } lamps_t;

  // Lamp pair for a state. Anything outside S0..S4 shows all-red.
  function automatic lamps_t decode_lamps(input state_e s);
    lamps_t l;
    case (s)
      S0:      begin l.hwy = GREEN;  l.cntry = RED;    end
      S1:      begin l.hwy = YELLOW; l.cntry = RED;    end
      S2:      begin l.hwy = RED;    l.cntry = RED;    end
      S3:      begin l.hwy = RED;    l.cntry = GREEN;  end
      S4:      begin l.hwy = RED;    l.cntry = YELLOW; end
      default: begin l.hwy = RED;    l.cntry = RED;    end
    endcase
    return l;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_if.sv
// Sensor and lamp bus of the traffic controller.
//   x         : country-road car present (sensor side -> controller)
//   hwy       : highway lamp code        (controller -> lamp driver)
//   cntry     : country-road lamp code   (controller -> lamp driver)
//   state_dbg : current controller state (controller -> observers)
// slave modport is the controller, master modport is the sensor/lamp side.
interface traffic_if;
  logic       x;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic [2:0] state_dbg;

  modport slave  (input  x, output hwy, output cntry, output state_dbg);
  modport master (output x, input  hwy, input  cntry, input  state_dbg);
endinterface

// File: rtl/traffic_signal_dwell_timer.sv
// Dwell timer: up-counter with synchronous clear and terminal-count compare.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear the count to 0 (has priority over en)
//   en       : count one cycle
//   limit    : number of enabled cycles to spend before done (>= 1)
//   done     : high during the last enabled cycle of the dwell
module dwell_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Count starts at 0 on state entry, so the limit-th cycle sees limit-1.
  assign done = en && (cnt_q == (limit - 1'b1));

endmodule

// File: rtl/traffic_signal.sv
// Moore controller for a highway / country-road intersection.
// Highway holds green until the country sensor requests a cycle:
// hwy yellow (Y2R_DELAY) -> all red (R2G_DELAY) -> country green while cars
// are present -> country yellow (Y2R_DELAY) -> back to highway green.
//   clk, rst   : clock, synchronous active-high reset
//   bus.x      : car present on the country road, sampled on rising edge
//   bus.hwy    : highway lamp code (registered, decode of state)
//   bus.cntry  : country lamp code (registered, decode of state)
//   bus.state_dbg : current state register
module traffic_signal
  import traffic_pkg::*;
#(
  parameter int Y2R_DELAY = 3,
  parameter int R2G_DELAY = 2
) (
  input  logic      clk,
  input  logic      rst,
  traffic_if.slave  bus
);

  localparam int CW = $clog2(max2(Y2R_DELAY, R2G_DELAY)) + 1;

  state_e          state;
  state_e          state_d;
  lamps_t          lamps_q;
  lamps_t          lamps_d;
  logic            timer_en;
  logic            timer_clr;
  logic            timer_done;
  logic [CW-1:0]   timer_limit;

  always_comb begin
    timer_en    = (state == S1) || (state == S2) || (state == S4);
    timer_limit = (state == S2) ? CW'(R2G_DELAY) : CW'(Y2R_DELAY);

    state_d = state;
    case (state)
      S0:      if (bus.x)      state_d = S1;
      S1:      if (timer_done) state_d = S2;
      S2:      if (timer_done) state_d = S3;
      S3:      if (!bus.x)     state_d = S4;
      S4:      if (timer_done) state_d = S0;
      default:                 state_d = S0;
    endcase

    // Count restarts on every state change and stays at 0 in S0/S3.
    timer_clr = (state_d != state) || !timer_en;

    // Lamps are registered from the next state so they always equal the
    // decode of the state register, with no path from x to the outputs.
    lamps_d = decode_lamps(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S0;
      lamps_q <= decode_lamps(S0);
    end else begin
      state   <= state_d;
      lamps_q <= lamps_d;
    end
  end

  dwell_timer #(.W(CW)) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .en    (timer_en),
    .limit (timer_limit),
    .done  (timer_done)
  );

  assign bus.hwy       = lamps_q.hwy;
  assign bus.cntry     = lamps_q.cntry;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_traffic_signal.sv
// Bench for traffic_signal: a default-parameter instance and a
// Y2R_DELAY=1 / R2G_DELAY=4 instance share clk, rst and x.
module tb_traffic_signal;
  import traffic_pkg::*;

  logic clk;
  logic rst;

  traffic_if bus_a ();
  traffic_if bus_b ();

  traffic_signal dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  traffic_signal #(.Y2R_DELAY(1), .R2G_DELAY(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase = which leg of the signal cycle is shown; secs = cycles already
  // spent in a timed leg. Lamps come from a per-phase lookup table.
  int n_cmp  = 0;
  int n_fail = 0;
  int ph[2]      = '{0, 0};
  int secs[2]    = '{0, 0};
  int y2r[2]     = '{3, 1};
  int r2g[2]     = '{2, 4};
  int hwy_tab[5] = '{2, 1, 0, 0, 0};
  int cty_tab[5] = '{0, 0, 0, 2, 1};

  task automatic model_step(input int i, input logic xv, input logic rv);
    if (rv) begin
      ph[i] = 0; secs[i] = 0;
    end else begin
      case (ph[i])
        0: if (xv) begin ph[i] = 1; secs[i] = 0; end
        1: begin secs[i]++; if (secs[i] == y2r[i]) begin ph[i] = 2; secs[i] = 0; end end
        2: begin secs[i]++; if (secs[i] == r2g[i]) begin ph[i] = 3; secs[i] = 0; end end
        3: if (!xv) begin ph[i] = 4; secs[i] = 0; end
        default: begin secs[i]++; if (secs[i] == y2r[i]) begin ph[i] = 0; secs[i] = 0; end end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("a_state",  8'(dut_a.state),     8'(ph[0]));
    chk("a_dbg",    8'(bus_a.state_dbg), 8'(ph[0]));
    chk("a_hwy",    8'(bus_a.hwy),       8'(hwy_tab[ph[0]]));
    chk("a_cntry",  8'(bus_a.cntry),     8'(cty_tab[ph[0]]));
    chk("a_excl",   8'(bus_a.hwy == RED || bus_a.cntry == RED), 8'd1);
    chk("b_state",  8'(dut_b.state),     8'(ph[1]));
    chk("b_hwy",    8'(bus_b.hwy),       8'(hwy_tab[ph[1]]));
    chk("b_cntry",  8'(bus_b.cntry),     8'(cty_tab[ph[1]]));
    chk("b_excl",   8'(bus_b.hwy == RED || bus_b.cntry == RED), 8'd1);
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, advance the model on the rising edge,
  // sample 1 ns after it.
  task automatic cyc(input logic xv, input logic rv);
    @(negedge clk);
    bus_a.x = xv;
    bus_b.x = xv;
    rst     = rv;
    @(posedge clk);
    model_step(0, xv, rv);
    model_step(1, xv, rv);
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic xr;
    int   run;
    rst = 1'b1;
    bus_a.x = 1'b0;
    bus_b.x = 1'b0;

    // Reset for two edges, then idle highway green.
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("rst_state", 8'(dut_a.state), 8'd0);
    chk("rst_hwy",   8'(bus_a.hwy),   8'd2);
    chk("rst_cntry", 8'(bus_a.cntry), 8'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);

    // Request: S1 x3, S2 x2, then S3 held while x stays high.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0);
    chk("hold_s3", 8'(dut_a.state), 8'd3);

    // Release, then re-request during S4: S4 keeps its dwell, S0 for one cycle.
    cyc(1'b0, 1'b0);
    chk("s4_entry", 8'(bus_a.cntry), 8'd1);
    for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0);

    // Reset while in S3 with x high, then release with x still high.
    cyc(1'b1, 1'b1);
    chk("mid_rst_state", 8'(dut_a.state), 8'd0);
    chk("mid_rst_hwy",   8'(bus_a.hwy),   8'd2);
    cyc(1'b1, 1'b0);
    chk("post_rst_s1",   8'(dut_a.state), 8'd1);

    // Randomized sensor traffic with occasional resets.
    run = 0;
    xr  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (run == 0) begin
        xr  = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 12);
      end
      run--;
      cyc(xr, ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
